ex_div: RTL and testbench

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div.sv | 125 ++++++++++++
 tb/tb_ex_div.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module ex_div (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        flush_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        busy_o,
    output logic [4:0]  reg_waddr_o
);
    typedef enum logic [1:0] {IDLE, START, CALC, END} state_t;
    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] rem_q;
    logic [5:0]  cnt_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [4:0]  waddr_q;
    logic        signed_op;
    logic        is_rem;
    logic        ge;
    logic [33:0] shifted;
    logic [33:0] diff;
    logic [32:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] res_calc;
    logic [31:0] res_zero;
    // One restoring shift-subtract step, and the sign fix-up applied on the final step
    always_comb begin
        signed_op = op_q[2] & ~op_q[0];
        is_rem    = op_q[1];
        shifted   = {rem_q, quo_q[31]};
        diff      = shifted - {2'b0, dvs_q};
        ge        = ~diff[33];
        rem_nxt   = ge ? diff[32:0] : shifted[32:0];
        quo_nxt   = {quo_q[30:0], ge};
        q_fin     = (signed_op && q_neg_q) ? -quo_nxt : quo_nxt;
        r_fin     = (signed_op && r_neg_q) ? -rem_nxt[31:0] : rem_nxt[31:0];
        res_calc  = is_rem ? r_fin : q_fin;
        res_zero  = is_rem ? quo_q : 32'hFFFF_FFFF;
    end
    // Control FSM; START spends two cycles (sign prep, then dispatch) so the zero and
    // nonzero divisor paths finish two and thirty-four edges after the start edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            op_q        <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            waddr_q     <= '0;
            result_o    <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            reg_waddr_o <= '0;
        end else begin
            done_o      <= 1'b0;
            result_o    <= '0;
            reg_waddr_o <= '0;
            if (flush_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        op_q    <= op_i;
                        quo_q   <= dividend_i;
                        dvs_q   <= divisor_i;
                        waddr_q <= reg_waddr_i;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state   <= START;
                    end
                    START: if (cnt_q == 6'd0) begin
                        if (dvs_q != '0 && signed_op) begin
                            quo_q <= quo_q[31] ? -quo_q : quo_q;
                            dvs_q <= dvs_q[31] ? -dvs_q : dvs_q;
                        end
                        q_neg_q <= quo_q[31] ^ dvs_q[31];
                        r_neg_q <= quo_q[31];
                        cnt_q   <= 6'd1;
                    end else begin
                        cnt_q <= '0;
                        if (dvs_q == '0) begin
                            state       <= END;
                            done_o      <= 1'b1;
                            result_o    <= res_zero;
                            reg_waddr_o <= waddr_q;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        quo_q <= quo_nxt;
                        rem_q <= rem_nxt;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state       <= END;
                            done_o      <= 1'b1;
                            result_o    <= res_calc;
                            reg_waddr_o <= waddr_q;
                        end
                    end
                    END: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: scoreboard bench for the multi-cycle divider
`timescale 1ns/1ps
module tb_ex_div;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] result_o;
    logic        done_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  waddr;
    } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    ex_div dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
        .flush_i(flush_i), .result_o(result_o), .done_o(done_o), .busy_o(busy_o),
        .reg_waddr_o(reg_waddr_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return op[1] ? a % b : a / b;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [31:0] want, input string name,
                          input bit hold_start = 1'b0);
        int cyc = 0;
        int lat;
        bit leak = 1'b0;
        exp_t e;
        lat = (b == 32'd0) ? 2 : 34;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa;
        sb.push_back('{res: want, waddr: wa});
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0; op_i = 3'($urandom); dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = 5'($urandom);
        while (!done_o && cyc < 60) begin
            if (result_o !== 32'd0 || reg_waddr_o !== 5'd0 || busy_o !== 1'b1) leak = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            cyc++;
        end
        n_checks++;
        if (cyc !== lat) begin n_fail++; $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, lat); end
        n_checks++;
        if (leak) begin n_fail++; $display("FAIL %s idle_outputs: got nonzero result/waddr or busy=0 before done, want 0/0/busy=1", name); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (result_o !== e.res) begin n_fail++; $display("FAIL %s result: got %h, want %h", name, result_o, e.res); end
        n_checks++;
        if (reg_waddr_o !== e.waddr || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL %s waddr/busy: got %0d/%b, want %0d/1", name, reg_waddr_o, busy_o, e.waddr);
        end
        if (hold_start) begin
            start_i = 1'b1; op_i = DIVU; dividend_i = 32'd50; divisor_i = 32'd5;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        n_checks++;
        if ({done_o, busy_o, result_o, reg_waddr_o} !== 39'd0) begin
            n_fail++; $display("FAIL %s after_done: got done=%b busy=%b res=%h wa=%0d, want all 0", name, done_o, busy_o, result_o, reg_waddr_o);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; start_i = 1'b1; op_i = DIVU; dividend_i = 32'd10; divisor_i = 32'd2; reg_waddr_i = 5'd3;
        #1;
        n_checks++;
        if ({done_o, busy_o, result_o, reg_waddr_o} !== 39'd0) begin
            n_fail++; $display("FAIL reset_initial: got done=%b busy=%b res=%h, want all 0", done_o, busy_o, result_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({done_o, busy_o, result_o, reg_waddr_o} !== 39'd0) begin
            n_fail++; $display("FAIL reset_held: got done=%b busy=%b res=%h, want all 0", done_o, busy_o, result_o);
        end
        start_i = 1'b0;
        rst_n_i = 1'b1;
    endtask

    task automatic test_unsigned();
        run_op(DIVU, 32'd100, 32'd7, 5'd1, 32'd14, "divu_100_7");
        run_op(REMU, 32'd100, 32'd7, 5'd2, 32'd2, "remu_100_7");
        run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, "divu_max_1");
    endtask

    task automatic test_signed();
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, "div_m7_2");
        run_op(REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, "rem_m7_2");
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFD, "div_7_m2");
    endtask

    task automatic test_div_zero();
        run_op(DIVU, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, "divu_by0");
        run_op(REMU, 32'd5, 32'd0, 5'd8, 32'd5, "remu_by0");
        run_op(REM, 32'hFFFF_FFF9, 32'd0, 5'd9, 32'hFFFF_FFF9, "rem_neg_by0");
    endtask

    task automatic test_overflow();
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "div_overflow");
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, "rem_overflow");
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1; op_i = DIVU; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd3; reg_waddr_i = 5'd12;
        sb.push_back('{res: 32'h5555_5555, waddr: 5'd12});
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (12) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        sb.delete();
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_calc: got busy=%b done=%b, want 0/0", busy_o, done_o);
        end
        repeat (40) begin
            if (done_o) seen = 1'b1;
            @(negedge clk_i);
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL flush_no_done: got a done pulse, want none"); end
        run_op(DIVU, 32'd9, 32'd3, 5'd13, 32'd3, "divu_after_flush");
    endtask

    task automatic test_flush_start_idle();
        bit seen = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = DIVU; dividend_i = 32'd8; divisor_i = 32'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_wins_busy: got busy=%b, want 0", busy_o); end
        repeat (5) begin
            if (done_o) seen = 1'b1;
            @(negedge clk_i);
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL flush_wins_done: got a done pulse, want none"); end
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        start_i = 1'b1; op_i = DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd14;
        sb.push_back('{res: 32'd333, waddr: 5'd14});
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (15) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if ({done_o, busy_o, result_o, reg_waddr_o} !== 39'd0) begin
            n_fail++; $display("FAIL async_reset: got done=%b busy=%b res=%h, want all 0", done_o, busy_o, result_o);
        end
        @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        run_op(DIVU, 32'd100, 32'd7, 5'd15, 32'd14, "first_after_reset", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            op = {1'b1, 2'($urandom)};
            a = $urandom;
            b = (i == 3) ? 32'd0 : (i[0] ? 32'($urandom_range(1, 20)) : $urandom);
            if (i == 5) b = -32'd5;
            run_op(op, a, b, 5'(i + 16), model(op, a, b), $sformatf("rand%0d", i), i[1]);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_flush_start_idle();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
